alu_issue_stage: RTL

- Operand-issue and writeback stage wrapped around the 16-bit combinational ALU.
- Accepts decoded instructions over a valid/ready handshake and reads operands from an internal register file, with bypass from the in-flight result.
- Drives registered operands and op code to the ALU, then writes the ALU result and Z/C/V flags back one cycle later.
- Sits between the decoder (upstream) and the ALU (downstream).

---
 rtl/alu_issue_stage_if.sv | 36 +++
 rtl/alu_issue_stage.sv | 96 +++++++++
 2 files changed

// File: rtl/alu_issue_stage_if.sv
// Bundles the decoder-side issue handshake and the ALU operand/result bus
// seen by alu_issue_stage.
interface alu_issue_stage_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [IDX_W-1:0]  in_rd;
  logic [IDX_W-1:0]  in_rs1;
  logic [IDX_W-1:0]  in_rs2;
  logic              in_use_imm;
  logic [DATA_W-1:0] in_imm;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_op_code;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              alu_carry;
  logic              alu_overflow;

  // master: decoder and ALU side; slave: the issue stage itself
  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_use_imm, in_imm,
    output alu_result, alu_zero, alu_carry, alu_overflow,
    input  in_ready, alu_a, alu_b, alu_op_code
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_use_imm, in_imm,
    input  alu_result, alu_zero, alu_carry, alu_overflow,
    output in_ready, alu_a, alu_b, alu_op_code
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Operand issue and writeback around a combinational ALU: register file with
// result bypass, one execute slot, writeback pulse, status flags and retire counter.
module alu_issue_stage #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  alu_issue_stage_if.slave            bus,
  input  logic                        stall,
  output logic                        wb_valid,
  output logic [$clog2(NUM_REGS)-1:0] wb_rd,
  output logic [DATA_W-1:0]           wb_data,
  output logic [2:0]                  flags_zcv,
  output logic [15:0]                 retire_count,
  input  logic [$clog2(NUM_REGS)-1:0] dbg_addr,
  output logic [DATA_W-1:0]           dbg_data
);
  localparam int IDX_W = $clog2(NUM_REGS);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              ex_valid;
  logic [IDX_W-1:0]  ex_rd;
  logic              retire;
  logic              accept;
  logic [DATA_W-1:0] rs1_val;
  logic [DATA_W-1:0] rs2_val;
  logic [DATA_W-1:0] op_b;

  assign bus.in_ready = !stall;
  assign retire       = ex_valid && !stall;
  assign accept       = bus.in_valid && !stall;

  // The in-flight result is forwarded because it is written on the same edge
  // the reader is accepted; r0 is never forwarded.
  always_comb begin
    rs1_val = regs[bus.in_rs1];
    rs2_val = regs[bus.in_rs2];
    if (ex_valid && ex_rd == bus.in_rs1 && bus.in_rs1 != '0) begin
      rs1_val = bus.alu_result;
    end
    if (ex_valid && ex_rd == bus.in_rs2 && bus.in_rs2 != '0) begin
      rs2_val = bus.alu_result;
    end
    op_b = bus.in_use_imm ? bus.in_imm : rs2_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (retire && ex_rd != '0) begin
      regs[ex_rd] <= bus.alu_result;
    end
  end

  // Execute slot; operands keep their last values once the slot empties.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid        <= 1'b0;
      ex_rd           <= '0;
      bus.alu_a       <= '0;
      bus.alu_b       <= '0;
      bus.alu_op_code <= '0;
    end else if (accept) begin
      ex_valid        <= 1'b1;
      ex_rd           <= bus.in_rd;
      bus.alu_a       <= rs1_val;
      bus.alu_b       <= op_b;
      bus.alu_op_code <= bus.in_op;
    end else if (retire) begin
      ex_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      flags_zcv    <= '0;
      retire_count <= '0;
    end else begin
      wb_valid <= retire;
      if (retire) begin
        wb_rd        <= ex_rd;
        wb_data      <= bus.alu_result;
        flags_zcv    <= {bus.alu_zero, bus.alu_carry, bus.alu_overflow};
        retire_count <= retire_count + 16'd1;
      end
    end
  end

  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
endmodule
